// File: rtl/health_manager_pkg.sv
// -----------------------------------------------------------------------------
// health_manager_pkg
// Shared definitions for the health manager slice:
//   - hm_state_e : life-cycle state of the player (ALIVE, INVULN, DEAD)
//   - HM_*       : default parameter values used by health_manager
// -----------------------------------------------------------------------------
package health_manager_pkg;

   typedef enum logic [1:0] {
      ALIVE  = 2'd0,
      INVULN = 2'd1,
      DEAD   = 2'd2
   } hm_state_e;

   localparam int HM_HP_W         = 4;
   localparam int HM_HP_MAX       = 8;
   localparam int HM_N_SRC        = 2;
   localparam int HM_DMG_W        = 2;
   localparam int HM_TICK_DIV     = 6000000;
   localparam int HM_IFRAME_TICKS = 16;

endpackage

// File: rtl/health_manager_tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Free-running prescaler counting 0..DIV-1 while enabled, wrapping to 0.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; counter to 0
//   clr   : synchronous clear; holds the counter at 0 (wins over en)
//   en    : count enable
//   tick  : high in the cycle the counter sits at DIV-1 while enabled,
//           i.e. the cycle in which it wraps
// -----------------------------------------------------------------------------
module tick_divider #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   // DIV=1 would give a zero-width counter; keep at least one bit.
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en & ~clr & (cnt_q == LAST);

endmodule

// File: rtl/health_manager.sv
// -----------------------------------------------------------------------------
// health_manager
// Tracks a player's health, applies damage from N_SRC channels and heals,
// runs a timed invulnerability window after each hit, and latches death.
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous, active-high; overrides every other input
//   dmg_valid  : per-channel damage request (N_SRC)
//   dmg_amt    : per-channel damage amount, channel i at [i*DMG_W +: DMG_W]
//   heal       : heal request
//   heal_amt   : heal amount
//   health     : registered current health
//   invuln     : high while in INVULN
//   blink      : invuln AND tick-count bit 0 (display flicker)
//   hit        : one-cycle pulse, aligned with the health update of an
//                accepted damage event
//   dead       : high while in DEAD
//   state_dbg  : current FSM state (hm_state_e encoding)
//
// Request semantics: dmg_valid and heal have no ready/backpressure. They are
// sampled on every rising edge; a request is either consumed in that cycle
// (accepted) or dropped (ignored by the current state). Nothing is queued.
// -----------------------------------------------------------------------------
module health_manager
   import health_manager_pkg::*;
#(
   parameter int HP_W         = HM_HP_W,
   parameter int HP_MAX       = HM_HP_MAX,
   parameter int N_SRC        = HM_N_SRC,
   parameter int DMG_W        = HM_DMG_W,
   parameter int TICK_DIV     = HM_TICK_DIV,
   parameter int IFRAME_TICKS = HM_IFRAME_TICKS
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_SRC-1:0]       dmg_valid,
   input  logic [N_SRC*DMG_W-1:0] dmg_amt,
   input  logic                   heal,
   input  logic [HP_W-1:0]        heal_amt,
   output logic [HP_W-1:0]        health,
   output logic                   invuln,
   output logic                   blink,
   output logic                   hit,
   output logic                   dead,
   output logic [1:0]             state_dbg
);

   localparam int DSUM_W = HP_W + 1;
   localparam int TC_W   = $clog2(IFRAME_TICKS + 1);
   // Signed width wide enough for health + heal_amt - dmg_sum with no wrap.
   localparam int SW     = HP_W + 3;

   localparam logic [HP_W-1:0]      HP_FULL   = HP_W'(HP_MAX);
   localparam logic signed [SW-1:0] HP_MAX_S  = SW'(HP_MAX);
   localparam logic [TC_W-1:0]      TC_LAST   = TC_W'(IFRAME_TICKS - 1);

   hm_state_e         state_q, state_d;
   logic [HP_W-1:0]   health_q, health_d;
   logic              hit_q, hit_d;
   logic [TC_W-1:0]   tcnt_q, tcnt_d;

   logic [DSUM_W-1:0] dmg_sum;
   logic              dmg_acc;
   logic              heal_acc;
   logic signed [SW-1:0] h_sum;
   logic [HP_W-1:0]   h_next;
   logic              tick;

   // Sum of all valid channels, deliberately kept at HP_W+1 bits.
   always_comb begin
      dmg_sum = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (dmg_valid[i]) begin
            dmg_sum = dmg_sum + DSUM_W'(dmg_amt[i*DMG_W +: DMG_W]);
         end
      end
   end

   assign dmg_acc  = (state_q == ALIVE) && (dmg_sum != '0);
   assign heal_acc = (state_q != DEAD) && heal;

   // Single signed step, then clamp to [0, HP_MAX].
   always_comb begin
      h_sum = $signed({3'b000, health_q});
      if (dmg_acc) begin
         h_sum = h_sum - $signed({2'b00, dmg_sum});
      end
      if (heal_acc) begin
         h_sum = h_sum + $signed({3'b000, heal_amt});
      end
      if (h_sum[SW-1]) begin
         h_next = '0;
      end else if (h_sum > HP_MAX_S) begin
         h_next = HP_FULL;
      end else begin
         h_next = h_sum[HP_W-1:0];
      end
   end

   // Prescaler only runs inside INVULN; it is held at 0 everywhere else,
   // so it is already 0 on the first INVULN cycle.
   tick_divider #(
      .DIV (TICK_DIV)
   ) u_tick_divider (
      .clk   (clk),
      .reset (reset),
      .clr   (state_q != INVULN),
      .en    (state_q == INVULN),
      .tick  (tick)
   );

   always_comb begin
      state_d  = state_q;
      health_d = health_q;
      hit_d    = 1'b0;
      tcnt_d   = tcnt_q;
      case (state_q)
         ALIVE: begin
            health_d = h_next;
            tcnt_d   = '0;
            if (dmg_acc) begin
               hit_d   = 1'b1;
               state_d = (h_next == '0) ? DEAD : INVULN;
            end
         end
         INVULN: begin
            health_d = h_next;
            // Window ends on the wrap that completes tick IFRAME_TICKS.
            if (tick) begin
               if (tcnt_q == TC_LAST) begin
                  state_d = ALIVE;
                  tcnt_d  = '0;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
         end
         DEAD: begin
            health_d = '0;
            tcnt_d   = '0;
         end
         default: begin
            state_d  = ALIVE;
            tcnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ALIVE;
         health_q <= HP_FULL;
         hit_q    <= 1'b0;
         tcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         health_q <= health_d;
         hit_q    <= hit_d;
         tcnt_q   <= tcnt_d;
      end
   end

   assign health    = health_q;
   assign invuln    = (state_q == INVULN);
   assign blink     = invuln & tcnt_q[0];
   assign hit       = hit_q;
   assign dead      = (state_q == DEAD);
   assign state_dbg = state_q;

endmodule
